instr_sequencer: RTL and testbench

Multi-cycle control FSM for the Jac1-8 core. It sequences fetch, decode and execute around the combinational instruction decoder. It gates the decoder's write strobes into single-cycle commit pulses for the register file, status register and program counter. It also provides run/halt/single-step debug control, reserved-opcode trapping and a retired-instruction counter.

---
 rtl/instr_sequencer_if.sv | 42 ++++
 rtl/instr_sequencer.sv | 101 ++++++++++
 tb/tb_instr_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Bundles the sequencer's control, fetch and commit-strobe signals.
// The master side is the core/debug host. The slave side is the sequencer.
interface instr_sequencer_if #(
    parameter int COUNT_WIDTH   = 16,
    parameter int NumOpCodeBits = 5
);
    logic                     run;
    logic                     step;
    logic                     halt_req;
    logic                     imem_ready;
    logic [NumOpCodeBits-1:0] opcode;
    logic                     dec_wr_en;
    logic                     dec_stat_wr_en;
    logic                     dec_cnt_wr_en;
    logic                     dec_add_offset;

    logic                     imem_rd_en;
    logic                     ir_load;
    logic                     pc_inc;
    logic                     pc_load;
    logic                     pc_add_offset;
    logic                     reg_wr_en;
    logic                     stat_wr_en;
    logic                     halted;
    logic                     illegal;
    logic [1:0]               state;
    logic [COUNT_WIDTH-1:0]   instr_count;

    modport master (
        output run, step, halt_req, imem_ready, opcode,
               dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset,
        input  imem_rd_en, ir_load, pc_inc, pc_load, pc_add_offset,
               reg_wr_en, stat_wr_en, halted, illegal, state, instr_count
    );

    modport slave (
        input  run, step, halt_req, imem_ready, opcode,
               dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset,
        output imem_rd_en, ir_load, pc_inc, pc_load, pc_add_offset,
               reg_wr_en, stat_wr_en, halted, illegal, state, instr_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Jac1-8 fetch/decode/execute sequencer with run/halt/single-step control,
// reserved-opcode trapping and a retired-instruction counter.
module instr_sequencer #(
    parameter int COUNT_WIDTH   = 16,
    parameter int NumOpCodeBits = 5
) (
    input  logic            clk,
    input  logic            reset,
    instr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        HALT   = 2'b00,
        FETCH  = 2'b01,
        DECODE = 2'b10,
        EXEC   = 2'b11
    } state_e;

    localparam logic [NumOpCodeBits-1:0] ResALo = NumOpCodeBits'(10);
    localparam logic [NumOpCodeBits-1:0] ResAHi = NumOpCodeBits'(15);
    localparam logic [NumOpCodeBits-1:0] ResBLo = NumOpCodeBits'(22);

    state_e                 r_state;
    logic                   r_single;
    logic                   r_haltPend;
    logic                   r_illegal;
    logic [COUNT_WIDTH-1:0] r_count;

    logic w_reserved;
    logic w_fetch;
    logic w_exec;
    logic w_stopAfterExec;

    assign w_reserved = ((bus.opcode >= ResALo) && (bus.opcode <= ResAHi)) ||
                        (bus.opcode >= ResBLo);

    // Strobes are suppressed while reset is high so nothing commits on the reset edge.
    assign w_fetch = (r_state == FETCH) && !reset;
    assign w_exec  = (r_state == EXEC)  && !reset;

    assign w_stopAfterExec = r_haltPend || r_single || !bus.run || bus.halt_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HALT;
            r_single   <= 1'b0;
            r_haltPend <= 1'b0;
            r_illegal  <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                HALT: begin
                    if (bus.run || bus.step) begin
                        r_state    <= FETCH;
                        r_single   <= !bus.run;
                        r_illegal  <= 1'b0;
                        r_haltPend <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.halt_req) begin
                        r_haltPend <= 1'b1;
                    end
                    if (bus.imem_ready) begin
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (bus.halt_req) begin
                        r_haltPend <= 1'b1;
                    end
                    // A trap leaves the PC on the offending instruction for the debugger.
                    if (w_reserved) begin
                        r_state   <= HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                    r_state <= w_stopAfterExec ? HALT : FETCH;
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign bus.imem_rd_en    = w_fetch;
    assign bus.ir_load       = w_fetch && bus.imem_ready;
    assign bus.reg_wr_en     = w_exec && bus.dec_wr_en;
    assign bus.stat_wr_en    = w_exec && bus.dec_stat_wr_en;
    assign bus.pc_load       = w_exec && bus.dec_cnt_wr_en;
    assign bus.pc_add_offset = w_exec && bus.dec_cnt_wr_en && bus.dec_add_offset;
    assign bus.pc_inc        = w_exec && !bus.dec_cnt_wr_en;
    assign bus.halted        = (r_state == HALT);
    assign bus.illegal       = r_illegal;
    assign bus.state         = r_state;
    assign bus.instr_count   = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Table-driven bench for instr_sequencer: one row per clock cycle of inputs
// with the outputs expected in that same cycle, plus wrap and reset-in-EXEC sequences.
module tb_instr_sequencer;

    localparam int CW = 4;
    localparam int OW = 5;

    localparam logic [4:0] OpAdd  = 5'b00000;
    localparam logic [4:0] OpVal  = 5'b00001;
    localparam logic [4:0] OpGoto = 5'b00010;
    localparam logic [4:0] OpIfz  = 5'b00011;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_sequencer_if #(.COUNT_WIDTH(CW), .NumOpCodeBits(OW)) bus ();

    instr_sequencer #(.COUNT_WIDTH(CW), .NumOpCodeBits(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ins = {reset, run, step, halt_req, imem_ready}, dec = {wr, stat, cnt, add},
    // outs = {imem_rd_en, ir_load, pc_inc, pc_load, pc_add_offset, reg_wr_en, stat_wr_en, illegal}
    typedef struct {
        logic          chk;
        logic [4:0]    ins;
        logic [4:0]    op;
        logic [3:0]    dec;
        logic [1:0]    st;
        logic [7:0]    outs;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic vec_t mk(input logic chk, input logic [4:0] ins, input logic [4:0] op,
                                input logic [3:0] dec, input logic [1:0] st,
                                input logic [7:0] outs, input int cnt);
        vec_t v;
        v.chk  = chk;
        v.ins  = ins;
        v.op   = op;
        v.dec  = dec;
        v.st   = st;
        v.outs = outs;
        v.cnt  = CW'(cnt);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset              = v.ins[4];
        bus.run            = v.ins[3];
        bus.step           = v.ins[2];
        bus.halt_req       = v.ins[1];
        bus.imem_ready     = v.ins[0];
        bus.opcode         = v.op;
        bus.dec_wr_en      = v.dec[3];
        bus.dec_stat_wr_en = v.dec[2];
        bus.dec_cnt_wr_en  = v.dec[1];
        bus.dec_add_offset = v.dec[0];
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic [10:0] act;
        logic [10:0] exp;
        if (v.chk) begin
            act = {bus.state, bus.imem_rd_en, bus.ir_load, bus.pc_inc, bus.pc_load,
                   bus.pc_add_offset, bus.reg_wr_en, bus.stat_wr_en, bus.halted, bus.illegal};
            exp = {v.st, v.outs[7:1], (v.st == 2'b00), v.outs[0]};
            checks++;
            if (act !== exp) begin
                fails++;
                $display("[TB] FAIL %s outputs {state,rd,irl,inc,ld,add,rw,sw,halted,ill}: got %b expected %b",
                         name, act, exp);
            end
            checks++;
            if (bus.instr_count !== v.cnt) begin
                fails++;
                $display("[TB] FAIL %s instr_count: got %0d expected %0d", name, bus.instr_count, v.cnt);
            end
        end
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    task automatic doReset();
        repeat (2) applyStimulus(mk(1'b0, 5'b10000, 5'd0, 4'b0000, 2'd0, 8'h00, 0));
    endtask

    initial begin
        reset              = 1'b1;
        bus.run            = 1'b0;
        bus.step           = 1'b0;
        bus.halt_req       = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.opcode         = '0;
        bus.dec_wr_en      = 1'b0;
        bus.dec_stat_wr_en = 1'b0;
        bus.dec_cnt_wr_en  = 1'b0;
        bus.dec_add_offset = 1'b0;

        // Continuous ADD, VAL, GOTO; run drops for IFZ with relative branch.
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd0, 8'b00000000, 0));
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 0));
        vecs.push_back(mk(1, 5'b01001, OpAdd,   4'b0000, 2'd2, 8'b00000000, 0));
        vecs.push_back(mk(1, 5'b01001, OpAdd,   4'b1100, 2'd3, 8'b00100110, 0));
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 1));
        vecs.push_back(mk(1, 5'b01001, OpVal,   4'b0000, 2'd2, 8'b00000000, 1));
        vecs.push_back(mk(1, 5'b01001, OpVal,   4'b1000, 2'd3, 8'b00100100, 1));
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 2));
        vecs.push_back(mk(1, 5'b01001, OpGoto,  4'b0000, 2'd2, 8'b00000000, 2));
        vecs.push_back(mk(1, 5'b01001, OpGoto,  4'b0010, 2'd3, 8'b00010000, 2));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 3));
        vecs.push_back(mk(1, 5'b00001, OpIfz,   4'b0000, 2'd2, 8'b00000000, 3));
        vecs.push_back(mk(1, 5'b00001, OpIfz,   4'b0011, 2'd3, 8'b00011000, 3));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000000, 4));
        // Single step with two wait cycles in FETCH; step in DECODE is ignored.
        vecs.push_back(mk(1, 5'b00100, 5'd0,    4'b0000, 2'd0, 8'b00000000, 4));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd1, 8'b10000000, 4));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd1, 8'b10000000, 4));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 4));
        vecs.push_back(mk(1, 5'b00100, OpIfz,   4'b0000, 2'd2, 8'b00000000, 4));
        vecs.push_back(mk(1, 5'b00000, OpIfz,   4'b0000, 2'd3, 8'b00100000, 4));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000000, 5));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd0, 8'b00000000, 5));
        // halt_req in FETCH with run held: instruction completes, then HALT.
        vecs.push_back(mk(1, 5'b01000, 5'd0,    4'b0000, 2'd0, 8'b00000000, 5));
        vecs.push_back(mk(1, 5'b01010, 5'd0,    4'b0000, 2'd1, 8'b10000000, 5));
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 5));
        vecs.push_back(mk(1, 5'b01001, OpAdd,   4'b0000, 2'd2, 8'b00000000, 5));
        vecs.push_back(mk(1, 5'b01001, OpAdd,   4'b1000, 2'd3, 8'b00100100, 5));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000000, 6));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd0, 8'b00000000, 6));
        // Reserved opcodes trap in DECODE; step clears the sticky flag.
        vecs.push_back(mk(1, 5'b00100, 5'd0,    4'b0000, 2'd0, 8'b00000000, 6));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'b01010, 4'b1111, 2'd2, 8'b00000000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b1111, 2'd0, 8'b00000001, 6));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000001, 6));
        vecs.push_back(mk(1, 5'b00100, 5'd0,    4'b0000, 2'd0, 8'b00000001, 6));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'b11111, 4'b0000, 2'd2, 8'b00000000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000001, 6));
        vecs.push_back(mk(1, 5'b00100, 5'd0,    4'b0000, 2'd0, 8'b00000001, 6));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'b10100, 4'b0000, 2'd2, 8'b00000000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'b10100, 4'b0000, 2'd3, 8'b00100000, 6));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000000, 7));
        // run and step together: run wins, so execution continues after EXEC.
        vecs.push_back(mk(1, 5'b01100, 5'd0,    4'b0000, 2'd0, 8'b00000000, 7));
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 7));
        vecs.push_back(mk(1, 5'b01001, 5'b10101, 4'b0000, 2'd2, 8'b00000000, 7));
        vecs.push_back(mk(1, 5'b01001, 5'b10101, 4'b1000, 2'd3, 8'b00100100, 7));
        vecs.push_back(mk(1, 5'b01001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 8));
        vecs.push_back(mk(1, 5'b01001, 5'b01001, 4'b0000, 2'd2, 8'b00000000, 8));
        vecs.push_back(mk(1, 5'b00000, 5'b01001, 4'b0000, 2'd3, 8'b00100000, 8));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000000, 9));
        vecs.push_back(mk(1, 5'b00100, 5'd0,    4'b0000, 2'd0, 8'b00000000, 9));
        vecs.push_back(mk(1, 5'b00001, 5'd0,    4'b0000, 2'd1, 8'b11000000, 9));
        vecs.push_back(mk(1, 5'b00000, 5'b10110, 4'b0000, 2'd2, 8'b00000000, 9));
        vecs.push_back(mk(1, 5'b00000, 5'd0,    4'b0000, 2'd0, 8'b00000001, 9));

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while illegal=1 clears it; then 15 retirements and one more wraps to 0.
        doReset();
        runVec(mk(1, 5'b01001, 5'd0, 4'b0000, 2'd0, 8'b00000000, 0), "wrap_start");
        for (int c = 1; c <= 45; c++) begin
            runVec(mk(0, 5'b01001, OpAdd, 4'b0000, 2'd0, 8'b00000000, 0), "wrap_run");
        end
        runVec(mk(1, 5'b01001, 5'd0,  4'b0000, 2'd1, 8'b11000000, 15), "wrap_15");
        runVec(mk(1, 5'b01001, OpAdd, 4'b0000, 2'd2, 8'b00000000, 15), "wrap_dec");
        runVec(mk(1, 5'b00001, OpAdd, 4'b0000, 2'd3, 8'b00100000, 15), "wrap_exec");
        runVec(mk(1, 5'b00000, 5'd0,  4'b0000, 2'd0, 8'b00000000, 0),  "wrap_zero");

        // Reset during EXEC: no commit strobes that cycle, then HALT with count 0.
        runVec(mk(1, 5'b01000, 5'd0,  4'b0000, 2'd0, 8'b00000000, 0), "rst_halt");
        runVec(mk(1, 5'b01001, 5'd0,  4'b0000, 2'd1, 8'b11000000, 0), "rst_fetch");
        runVec(mk(1, 5'b01001, OpAdd, 4'b0000, 2'd2, 8'b00000000, 0), "rst_decode");
        runVec(mk(1, 5'b11001, OpAdd, 4'b1111, 2'd3, 8'b00000000, 0), "rst_in_exec");
        runVec(mk(1, 5'b00000, 5'd0,  4'b0000, 2'd0, 8'b00000000, 0), "rst_after");
        runVec(mk(1, 5'b00000, 5'd0,  4'b0000, 2'd0, 8'b00000000, 0), "rst_stay");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
